// File: rtl/cash_port_arbiter_if.sv
// Cache read-port bundle shared by the two requesters and the arbiter.
// The master side drives requests and strobes; the slave side (arbiter) drives grants and the cache port.
interface cash_port_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  i_req0;
  logic                  i_ren0;
  logic [DATA_WIDTH-1:0] i_addr0;
  logic                  i_req1;
  logic                  i_ren1;
  logic [DATA_WIDTH-1:0] i_addr1;
  logic                  o_gnt0;
  logic                  o_gnt1;
  logic                  o_cash_ren;
  logic [DATA_WIDTH-1:0] o_cash_addr;
  logic                  o_busy;

  modport master (
    output i_req0, i_ren0, i_addr0, i_req1, i_ren1, i_addr1,
    input  o_gnt0, o_gnt1, o_cash_ren, o_cash_addr, o_busy
  );

  modport slave (
    input  i_req0, i_ren0, i_addr0, i_req1, i_ren1, i_addr1,
    output o_gnt0, o_gnt1, o_cash_ren, o_cash_addr, o_busy
  );
endinterface

// File: rtl/cash_port_arbiter.sv
// Two-requester round-robin arbiter for the cache read port, with a bounded hold
// time: the owner is preempted after MAX_HOLD cycles while the other side waits.
module cash_port_arbiter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_HOLD   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cash_port_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_e;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_e                state_q, state_d;
  logic                  last_owner_q, last_owner_d;
  logic [7:0]            hold_cnt_q, hold_cnt_d;
  logic                  gnt0_q, gnt0_d;
  logic                  gnt1_q, gnt1_d;
  logic [DATA_WIDTH-1:0] addr_mux;

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    hold_cnt_d   = hold_cnt_q;

    case (state_q)
      IDLE: begin
        if (bus.i_req0 && bus.i_req1) state_d = last_owner_q ? GNT0 : GNT1;
        else if (bus.i_req0)          state_d = GNT0;
        else if (bus.i_req1)          state_d = GNT1;
      end
      GNT0: begin
        if (!bus.i_req0)                                state_d = bus.i_req1 ? GNT1 : IDLE;
        else if (bus.i_req1 && hold_cnt_q == HOLD_LAST) state_d = GNT1;
      end
      GNT1: begin
        if (!bus.i_req1)                                state_d = bus.i_req0 ? GNT0 : IDLE;
        else if (bus.i_req0 && hold_cnt_q == HOLD_LAST) state_d = GNT0;
      end
      default: state_d = IDLE;
    endcase

    if (state_d == GNT0 && state_q != GNT0) last_owner_d = 1'b0;
    if (state_d == GNT1 && state_q != GNT1) last_owner_d = 1'b1;

    // Hold time only accrues while the other side is actually waiting.
    if (state_d != state_q)
      hold_cnt_d = '0;
    else if ((state_q == GNT0 && bus.i_req1) || (state_q == GNT1 && bus.i_req0))
      hold_cnt_d = hold_cnt_q + 8'd1;

    gnt0_d = (state_d == GNT0);
    gnt1_d = (state_d == GNT1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
      hold_cnt_q   <= '0;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      hold_cnt_q   <= hold_cnt_d;
      gnt0_q       <= gnt0_d;
      gnt1_q       <= gnt1_d;
    end
  end

  always_comb begin
    addr_mux = '0;
    if (gnt0_q)      addr_mux = bus.i_addr0;
    else if (gnt1_q) addr_mux = bus.i_addr1;
  end

  assign bus.o_gnt0      = gnt0_q;
  assign bus.o_gnt1      = gnt1_q;
  assign bus.o_busy      = gnt0_q | gnt1_q;
  assign bus.o_cash_ren  = (gnt0_q & bus.i_ren0) | (gnt1_q & bus.i_ren1);
  assign bus.o_cash_addr = addr_mux;

endmodule

// File: tb/tb_cash_port_arbiter.sv
// Directed scenarios for the cache port arbiter, run with MAX_HOLD=4.
module tb_cash_port_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  cash_port_arbiter_if #(.DATA_WIDTH(8)) bus ();

  cash_port_arbiter #(.DATA_WIDTH(8), .MAX_HOLD(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit expired got running exp finished");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r0, input logic e0, input logic [7:0] a0,
                       input logic r1, input logic e1, input logic [7:0] a1);
    bus.i_req0 = r0; bus.i_ren0 = e0; bus.i_addr0 = a0;
    bus.i_req1 = r1; bus.i_ren1 = e1; bus.i_addr1 = a1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    tick();
    checks++; if (bus.o_gnt0 !== 1'b0) begin errors++; $display("FAIL reset_gnt0 got %b exp 0", bus.o_gnt0); end
    checks++; if (bus.o_gnt1 !== 1'b0) begin errors++; $display("FAIL reset_gnt1 got %b exp 0", bus.o_gnt1); end
    checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.o_busy); end
    checks++; if (bus.o_cash_ren !== 1'b0) begin errors++; $display("FAIL reset_ren got %b exp 0", bus.o_cash_ren); end
    checks++; if (bus.o_cash_addr !== 8'h00) begin errors++; $display("FAIL reset_addr got %h exp 00", bus.o_cash_addr); end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    drive(1'b1, 1'b1, 8'h10, 1'b0, 1'b0, 8'h00);
    tick();
    checks++; if (bus.o_gnt0 !== 1'b1) begin errors++; $display("FAIL single_gnt0 got %b exp 1", bus.o_gnt0); end
    checks++; if (bus.o_gnt1 !== 1'b0) begin errors++; $display("FAIL single_gnt1 got %b exp 0", bus.o_gnt1); end
    checks++; if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b exp 1", bus.o_busy); end
    checks++; if (bus.o_cash_ren !== 1'b1) begin errors++; $display("FAIL single_ren got %b exp 1", bus.o_cash_ren); end
    checks++; if (bus.o_cash_addr !== 8'h10) begin errors++; $display("FAIL single_addr got %h exp 10", bus.o_cash_addr); end
    drive(1'b0, 1'b0, 8'h10, 1'b0, 1'b0, 8'h00);
    tick();
    checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL single_release_busy got %b exp 0", bus.o_busy); end
    checks++; if (bus.o_cash_addr !== 8'h00) begin errors++; $display("FAIL single_release_addr got %h exp 00", bus.o_cash_addr); end
  endtask

  task automatic test_tie_handover();
    rst_n = 1'b0; #2; rst_n = 1'b1;
    drive(1'b1, 1'b1, 8'h11, 1'b1, 1'b1, 8'h22);
    tick();
    checks++; if (bus.o_gnt0 !== 1'b1) begin errors++; $display("FAIL tie_gnt0 got %b exp 1", bus.o_gnt0); end
    checks++; if (bus.o_cash_addr !== 8'h11) begin errors++; $display("FAIL tie_addr0 got %h exp 11", bus.o_cash_addr); end
    drive(1'b0, 1'b0, 8'h11, 1'b1, 1'b1, 8'h22);
    tick();
    checks++; if ({bus.o_gnt0, bus.o_gnt1} !== 2'b01) begin errors++; $display("FAIL handover_gnt got %b exp 01", {bus.o_gnt0, bus.o_gnt1}); end
    checks++; if (bus.o_cash_addr !== 8'h22) begin errors++; $display("FAIL handover_addr got %h exp 22", bus.o_cash_addr); end
    checks++; if (bus.o_cash_ren !== 1'b1) begin errors++; $display("FAIL handover_ren got %b exp 1", bus.o_cash_ren); end
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    tick();
    checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL handover_release got %b exp 0", bus.o_busy); end
  endtask

  task automatic test_round_robin();
    // Last owner is requester 1 here.
    drive(1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 8'h02);
    tick();
    checks++; if ({bus.o_gnt0, bus.o_gnt1} !== 2'b10) begin errors++; $display("FAIL rr_first got %b exp 10", {bus.o_gnt0, bus.o_gnt1}); end
    drive(1'b0, 1'b0, 8'h01, 1'b0, 1'b0, 8'h02);
    tick();
    checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL rr_idle1 got %b exp 0", bus.o_busy); end
    drive(1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 8'h02);
    tick();
    checks++; if ({bus.o_gnt0, bus.o_gnt1} !== 2'b01) begin errors++; $display("FAIL rr_second got %b exp 01", {bus.o_gnt0, bus.o_gnt1}); end
    drive(1'b0, 1'b0, 8'h01, 1'b0, 1'b0, 8'h02);
    tick();
    drive(1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 8'h02);
    tick();
    checks++; if ({bus.o_gnt0, bus.o_gnt1} !== 2'b10) begin errors++; $display("FAIL rr_third got %b exp 10", {bus.o_gnt0, bus.o_gnt1}); end
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    tick();
  endtask

  task automatic test_preempt();
    drive(1'b1, 1'b1, 8'hA0, 1'b0, 1'b0, 8'hB0);
    tick();
    checks++; if (bus.o_gnt0 !== 1'b1) begin errors++; $display("FAIL preempt_start got %b exp 1", bus.o_gnt0); end
    bus.i_req1 = 1'b1; bus.i_ren1 = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++; if ({bus.o_gnt0, bus.o_gnt1} !== 2'b10) begin errors++; $display("FAIL preempt_hold0 cyc %0d got %b exp 10", i, {bus.o_gnt0, bus.o_gnt1}); end
    end
    tick();
    checks++; if ({bus.o_gnt0, bus.o_gnt1} !== 2'b01) begin errors++; $display("FAIL preempt_to1 got %b exp 01", {bus.o_gnt0, bus.o_gnt1}); end
    checks++; if (bus.o_cash_addr !== 8'hB0) begin errors++; $display("FAIL preempt_addr1 got %h exp b0", bus.o_cash_addr); end
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++; if ({bus.o_gnt0, bus.o_gnt1} !== 2'b01) begin errors++; $display("FAIL preempt_hold1 cyc %0d got %b exp 01", i, {bus.o_gnt0, bus.o_gnt1}); end
    end
    tick();
    checks++; if ({bus.o_gnt0, bus.o_gnt1} !== 2'b10) begin errors++; $display("FAIL preempt_back0 got %b exp 10", {bus.o_gnt0, bus.o_gnt1}); end
    bus.i_req1 = 1'b0; bus.i_ren1 = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      checks++; if ({bus.o_gnt0, bus.o_gnt1} !== 2'b10) begin errors++; $display("FAIL preempt_solo cyc %0d got %b exp 10", i, {bus.o_gnt0, bus.o_gnt1}); end
    end
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    tick();
    checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL preempt_release got %b exp 0", bus.o_busy); end
  endtask

  task automatic test_ungranted_strobe();
    drive(1'b1, 1'b0, 8'h33, 1'b0, 1'b1, 8'h55);
    tick();
    checks++; if (bus.o_gnt0 !== 1'b1) begin errors++; $display("FAIL strobe_gnt0 got %b exp 1", bus.o_gnt0); end
    checks++; if (bus.o_cash_ren !== 1'b0) begin errors++; $display("FAIL strobe_ren_off got %b exp 0", bus.o_cash_ren); end
    checks++; if (bus.o_cash_addr !== 8'h33) begin errors++; $display("FAIL strobe_addr got %h exp 33", bus.o_cash_addr); end
    bus.i_ren0 = 1'b1;
    #1;
    checks++; if (bus.o_cash_ren !== 1'b1) begin errors++; $display("FAIL strobe_ren_on got %b exp 1", bus.o_cash_ren); end
    tick();
    checks++; if ({bus.o_gnt0, bus.o_gnt1} !== 2'b10) begin errors++; $display("FAIL strobe_no_effect got %b exp 10", {bus.o_gnt0, bus.o_gnt1}); end
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    tick();
  endtask

  task automatic test_async_reset();
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h77);
    tick();
    checks++; if (bus.o_gnt1 !== 1'b1) begin errors++; $display("FAIL areset_pre_gnt1 got %b exp 1", bus.o_gnt1); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.o_gnt1 !== 1'b0) begin errors++; $display("FAIL areset_gnt1 got %b exp 0", bus.o_gnt1); end
    checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL areset_busy got %b exp 0", bus.o_busy); end
    checks++; if (bus.o_cash_ren !== 1'b0) begin errors++; $display("FAIL areset_ren got %b exp 0", bus.o_cash_ren); end
    checks++; if (bus.o_cash_addr !== 8'h00) begin errors++; $display("FAIL areset_addr got %h exp 00", bus.o_cash_addr); end
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 8'h44, 1'b1, 1'b1, 8'h77);
    tick();
    checks++; if ({bus.o_gnt0, bus.o_gnt1} !== 2'b10) begin errors++; $display("FAIL areset_tie got %b exp 10", {bus.o_gnt0, bus.o_gnt1}); end
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_tie_handover();
    test_round_robin();
    test_preempt();
    test_ungranted_strobe();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cash_port_arbiter.md
CASH_PORT_ARBITER -- requirements
Module: cash_port_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, 8, width of cache address bus.
REQ-002 Parameter MAX_HOLD, 16, cycles the owner may keep the grant while the other requester waits (range 2..255).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 i_req0  input  1  requester 0 (IR loader) wants the cache read port; level, held for the whole burst.
REQ-006 i_ren0  input  1  requester 0 read strobe for this cycle.
REQ-007 i_addr0  input  DATA_WIDTH  requester 0 read address.
REQ-008 i_req1  input  1  requester 1 (data load unit) wants the port; level.
REQ-009 i_ren1  input  1  requester 1 read strobe.
REQ-010 i_addr1  input  DATA_WIDTH  requester 1 read address.
REQ-011 o_gnt0  output  1  registered grant to requester 0.
REQ-012 o_gnt1  output  1  registered grant to requester 1.
REQ-013 o_cash_ren  output  1  read enable to cache.
REQ-014 o_cash_addr  output  DATA_WIDTH  read address to cache.
REQ-015 o_busy  output  1  port owned by either requester.

Function
REQ-016 FSM states SHALL be IDLE, GNT0, GNT1; o_gnt0=1 only in GNT0, o_gnt1=1 only in GNT1, o_busy = o_gnt0|o_gnt1.
REQ-017 Grants SHALL be registered: a request sampled at edge N yields grant visible after edge N (1-cycle latency from request to grant).
REQ-018 IDLE: only i_req0 -> GNT0; only i_req1 -> GNT1; both -> requester other than last_owner; neither -> stay IDLE.
REQ-019 last_owner SHALL be a 1-bit register updated to the granted index on every entry into GNT0/GNT1.
REQ-020 GNTx with i_reqx=1 and hold limit not reached: stay GNTx.
REQ-021 GNTx with i_reqx=0: go directly to GNTy if i_reqy=1, else IDLE (no idle bubble on handover).
REQ-022 hold_cnt (8 bit) SHALL clear on every state change, increment each cycle in GNTx while i_reqy=1, hold while i_reqy=0.
REQ-023 GNTx with i_reqx=1, i_reqy=1, hold_cnt==MAX_HOLD-1: force transition to GNTy (preemption); requester x SHALL keep i_reqx high and stall while o_gntx=0.
REQ-024 o_cash_ren SHALL be (o_gnt0&i_ren0)|(o_gnt1&i_ren1), combinational from registered grants.
REQ-025 o_cash_addr SHALL be i_addr0 when o_gnt0, i_addr1 when o_gnt1, all zeros otherwise.
REQ-026 i_renx while o_gntx=0 SHALL be ignored (no cache access, no state effect).
REQ-027 Simultaneous release of x and new request of y in same cycle: treat as REQ-021 (grant y next cycle).
REQ-028 o_gnt0 and o_gnt1 SHALL never be 1 in the same cycle.

Reset
REQ-029 rst_n=0 SHALL immediately (asynchronously) force IDLE, last_owner=1, hold_cnt=0; outputs o_gnt0=0, o_gnt1=0, o_busy=0, o_cash_ren=0, o_cash_addr=0.
REQ-030 Reset asserted mid-burst SHALL drop the grant without waiting for a clock; after release, arbitration restarts from IDLE with requester 0 preferred on tie.
REQ-031 rst_n deassertion SHALL be synchronised by the surrounding design; first arbitration decision occurs on the first rising edge with rst_n=1.

Verification
REQ-032 Single requester: i_req0=1, i_ren0=1, i_addr0=0x10 at cycle 0 -> o_gnt0=1 at cycle 1, o_cash_ren=1, o_cash_addr=0x10; i_req0=0 -> IDLE next cycle, all outputs 0.
REQ-033 Tie after reset: i_req0=i_req1=1 same cycle -> GNT0 first; drop i_req0 -> GNT1 on next cycle, o_cash_addr follows i_addr1 with no idle cycle.
REQ-034 Round robin: after GNT1 served and released, both request in IDLE -> GNT0; after GNT0 released, both request again -> GNT1.
REQ-035 Preemption: MAX_HOLD=4, GNT0 held, i_req1 rises at cycle k -> o_gnt0 falls and o_gnt1 rises after edge k+4; i_req0 still high -> regains grant when i_req1 drops or after 4 more cycles.
REQ-036 Ungranted strobe: GNT0 active, i_ren1=1, i_addr1=0x55 -> o_cash_addr never 0x55, o_cash_ren only reflects i_ren0.
REQ-037 Async reset: rst_n pulled low between clock edges during GNT1 -> o_gnt1, o_busy, o_cash_ren go 0 before next edge; after release tie resolves to GNT0.
